// File: rtl/mac_ctrl_frame_tx.sv
// MAC control frame inserter: serialises a captured mcf_* request into a
// 60-byte (pre-FCS) control frame on the TX stream, between user frames.
module mac_ctrl_frame_tx #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         mcf_valid,
  output logic                         mcf_ready,
  input  logic [47:0]                  mcf_eth_dst,
  input  logic [47:0]                  mcf_eth_src,
  input  logic [15:0]                  mcf_eth_type,
  input  logic [15:0]                  mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,

  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,

  output logic                         stat_tx_mcf
);

  localparam int unsigned FRAME_BYTES = 60;
  localparam int unsigned BEATS       = (FRAME_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST_BYTES  = FRAME_BYTES - (BEATS - 1) * KEEP_WIDTH;
  localparam int unsigned PAD_BITS    = BEATS * DATA_WIDTH;
  localparam int unsigned PARAM_BITS  = MCF_PARAMS_SIZE * 8;

  localparam logic [KEEP_WIDTH-1:0] FULL_KEEP = {KEEP_WIDTH{1'b1}};
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_WIDTH - LAST_BYTES);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    MCF  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;

  logic [47:0]           dst_q;
  logic [47:0]           src_q;
  logic [15:0]           type_q;
  logic [15:0]           opcode_q;
  logic [PARAM_BITS-1:0] params_q;

  logic [PAD_BITS-1:0]   frame_pad;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  last_beat;

  // State register and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; the frame in flight is built only from these copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q    <= '0;
      src_q    <= '0;
      type_q   <= '0;
      opcode_q <= '0;
      params_q <= '0;
    end else if (capture) begin
      dst_q    <= mcf_eth_dst;
      src_q    <= mcf_eth_src;
      type_q   <= mcf_eth_type;
      opcode_q <= mcf_opcode;
      params_q <= mcf_params;
    end
  end

  // Wire-order byte image of the frame, zero padded to a whole number of beats
  always_comb begin
    frame_pad = '0;
    for (int i = 0; i < 6; i++) begin
      frame_pad[8*i +: 8]       = dst_q[8*(5-i) +: 8];
      frame_pad[8*(6+i) +: 8]   = src_q[8*(5-i) +: 8];
    end
    frame_pad[8*12 +: 8] = type_q[15:8];
    frame_pad[8*13 +: 8] = type_q[7:0];
    frame_pad[8*14 +: 8] = opcode_q[15:8];
    frame_pad[8*15 +: 8] = opcode_q[7:0];
    for (int i = 0; i < int'(MCF_PARAMS_SIZE); i++) begin
      frame_pad[8*(16+i) +: 8] = params_q[8*i +: 8];
    end
  end

  // Select the beat addressed by the counter
  always_comb begin
    beat_data = '0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (cnt_q == CNT_W'(b)) begin
        beat_data = frame_pad[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign last_beat = (cnt_q == LAST_CNT);

  // Next-state and output decode; user data passes through outside MCF
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    capture       = 1'b0;
    mcf_ready     = 1'b0;
    stat_tx_mcf   = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tvalid = s_axis_tvalid;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tuser  = s_axis_tuser;
    s_axis_tready = m_axis_tready;

    unique case (state_q)
      IDLE: begin
        if (mcf_valid) begin
          mcf_ready     = 1'b1;
          capture       = 1'b1;
          m_axis_tvalid = 1'b0;
          s_axis_tready = 1'b0;
          cnt_d         = '0;
          state_d       = MCF;
        end else if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = IDLE;
        end
      end

      MCF: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = beat_data;
        m_axis_tkeep  = last_beat ? LAST_KEEP : FULL_KEEP;
        m_axis_tlast  = last_beat;
        m_axis_tuser  = '0;
        if (m_axis_tready) begin
          if (last_beat) begin
            stat_tx_mcf = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Nothing is offered or accepted while reset is held
    if (!rst_n) begin
      mcf_ready     = 1'b0;
      capture       = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
      stat_tx_mcf   = 1'b0;
    end
  end

endmodule
